// File: rtl/pll_lock_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, qualifies a synchronized lock over a
// stability window, then releases the system reset after a hold time.
module pll_lock_reset_ctrl #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RESET_HOLD_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       ready,
  output logic [7:0] relock_count
);

  localparam int MAX_AB    = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CD    = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int MAX_COUNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W     = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  typedef enum logic [2:0] {
    S_PLL_RESET = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_HOLD      = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
    end
  endgenerate

  state_t                   state;
  state_t                   next_state;
  logic [CNT_W-1:0]         cnt;
  logic [SYNC_STAGES-1:0]   sync_chain;
  logic                     locked_s;
  logic                     rst_done;
  logic                     lock_timeout;
  logic                     stable_done;
  logic                     hold_done;
  logic                     relock_inc;

  // Metastability synchronizer for the asynchronous PLL lock flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign locked_s     = sync_chain[SYNC_STAGES-1];
  assign rst_done     = (cnt == RST_LAST);
  assign lock_timeout = (cnt == TIMEOUT_LAST);
  assign stable_done  = (cnt == STABLE_LAST);
  assign hold_done    = (cnt == HOLD_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_PLL_RESET;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; lock loss always outranks timeouts and soft reset requests.
  always_comb begin
    next_state = state;
    relock_inc = 1'b0;
    case (state)
      S_PLL_RESET: begin
        if (rst_done) begin
          next_state = S_WAIT_LOCK;
        end else begin
          next_state = S_PLL_RESET;
        end
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          next_state = S_STABILIZE;
        end else if (lock_timeout) begin
          next_state = S_PLL_RESET;
        end else begin
          next_state = S_WAIT_LOCK;
        end
      end
      S_STABILIZE: begin
        if (!locked_s) begin
          next_state = S_WAIT_LOCK;
        end else if (stable_done) begin
          next_state = S_HOLD;
        end else begin
          next_state = S_STABILIZE;
        end
      end
      S_HOLD: begin
        if (!locked_s) begin
          next_state = S_WAIT_LOCK;
        end else if (hold_done) begin
          next_state = S_RUN;
        end else begin
          next_state = S_HOLD;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          next_state = S_WAIT_LOCK;
          relock_inc = 1'b1;
        end else if (soft_reset_req) begin
          next_state = S_HOLD;
        end else begin
          next_state = S_RUN;
        end
      end
      default: begin
        next_state = S_PLL_RESET;
        relock_inc = 1'b0;
      end
    endcase
  end

  // Shared phase counter; restarts on every transition and idles in RUN so it never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (next_state != state) begin
      cnt <= '0;
    end else if (state == S_RUN) begin
      cnt <= cnt;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Saturating count of lock losses seen while running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      relock_count <= 8'd0;
    end else if (relock_inc && (relock_count != 8'd255)) begin
      relock_count <= relock_count + 8'd1;
    end else begin
      relock_count <= relock_count;
    end
  end

  // Outputs registered from next_state so they switch on the same edge as the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pll_rst     <= 1'b1;
      sys_reset_n <= 1'b0;
      ready       <= 1'b0;
    end else begin
      pll_rst     <= (next_state == S_PLL_RESET);
      sys_reset_n <= (next_state == S_RUN);
      ready       <= (next_state == S_RUN);
    end
  end

endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// Bench for pll_lock_reset_ctrl: directed sequencing scenarios plus random lock
// traffic, every cycle compared against a phase/time-remaining reference model.
module tb_pll_lock_reset_ctrl;

  localparam int SS  = 2;
  localparam int PRC = 8;
  localparam int LTO = 64;
  localparam int LSC = 8;
  localparam int RHC = 4;

  localparam int P_PR   = 0;
  localparam int P_WAIT = 1;
  localparam int P_STAB = 2;
  localparam int P_HOLD = 3;
  localparam int P_RUN  = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       soft_reset_req;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       ready;
  logic [7:0] relock_count;

  int vectors;
  int miscompares;

  int m_ph;
  int m_left;
  int m_relock;
  bit m_hist[$];

  always #5 clk = ~clk;

  pll_lock_reset_ctrl #(
    .SYNC_STAGES         (SS),
    .PLL_RST_CYCLES      (PRC),
    .LOCK_TIMEOUT_CYCLES (LTO),
    .LOCK_STABLE_CYCLES  (LSC),
    .RESET_HOLD_CYCLES   (RHC)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pll_locked     (pll_locked),
    .soft_reset_req (soft_reset_req),
    .pll_rst        (pll_rst),
    .sys_reset_n    (sys_reset_n),
    .ready          (ready),
    .relock_count   (relock_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int phase_len(input int p);
    case (p)
      P_PR:    return PRC;
      P_WAIT:  return LTO;
      P_STAB:  return LSC;
      P_HOLD:  return RHC;
      default: return 0;
    endcase
  endfunction

  task automatic model_enter(input int p);
    m_ph   = p;
    m_left = phase_len(p);
  endtask

  task automatic model_reset();
    model_enter(P_PR);
    m_relock = 0;
    m_hist   = {};
    for (int i = 0; i < SS; i++) m_hist.push_back(1'b0);
  endtask

  // One rising edge of the reference: lock seen SS edges late, timed phases count down.
  task automatic model_step(input bit pl, input bit sr);
    bit ls;
    ls = m_hist.pop_front();
    m_hist.push_back(pl);
    case (m_ph)
      P_PR: begin
        if (m_left == 1) model_enter(P_WAIT);
        else m_left--;
      end
      P_WAIT: begin
        if (ls) model_enter(P_STAB);
        else if (m_left == 1) model_enter(P_PR);
        else m_left--;
      end
      P_STAB, P_HOLD: begin
        if (!ls) model_enter(P_WAIT);
        else if (m_left == 1) model_enter(m_ph == P_STAB ? P_HOLD : P_RUN);
        else m_left--;
      end
      default: begin
        if (!ls) begin
          if (m_relock < 255) m_relock++;
          model_enter(P_WAIT);
        end else if (sr) begin
          model_enter(P_HOLD);
        end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step(pll_locked, soft_reset_req);
    #1;
    check_eq("pll_rst", pll_rst, (m_ph == P_PR) ? 1 : 0);
    check_eq("sys_reset_n", sys_reset_n, (m_ph == P_RUN) ? 1 : 0);
    check_eq("ready", ready, (m_ph == P_RUN) ? 1 : 0);
    check_eq("relock_count", relock_count, m_relock);
  endtask

  // Tick until the chosen output (0: sys_reset_n, 1: pll_rst) equals val; n counts ticks.
  task automatic wait_for(input int which, input logic val, input int limit, output int n);
    logic cur;
    n = 0;
    do begin
      tick();
      n++;
      cur = (which == 0) ? sys_reset_n : pll_rst;
    end while (cur !== val && n < limit);
  endtask

  initial begin
    int n;
    int h;
    int g;
    int low;
    int r0;
    int hold_left;

    vectors        = 0;
    miscompares    = 0;
    reset_n        = 1'b0;
    pll_locked     = 1'b0;
    soft_reset_req = 1'b0;
    model_reset();

    repeat (3) tick();
    reset_n = 1'b1;

    // Power-up PLL reset pulse width.
    wait_for(1, 1'b0, 200, n);
    check_eq("pll_rst_width", n, PRC);

    // Clean lock latency.
    repeat (20) tick();
    pll_locked = 1'b1;
    wait_for(0, 1'b1, 200, n);
    check_eq("lock_latency", n - 1, SS + LSC + RHC);
    repeat (30) tick();

    // Lock loss in RUN.
    pll_locked = 1'b0;
    wait_for(0, 1'b0, 50, n);
    check_eq("loss_latency", n, SS + 1);
    check_eq("relock_first", relock_count, 1);

    // Timeout re-pulses the PLL reset periodically.
    wait_for(1, 1'b1, 200, n);
    check_eq("timeout_wait", n, LTO);
    for (int k = 0; k < 2; k++) begin
      wait_for(1, 1'b0, 200, h);
      check_eq("repulse_width", h, PRC);
      wait_for(1, 1'b1, 200, g);
      check_eq("repulse_period", h + g, PRC + LTO);
    end

    // Glitch during stabilization restarts qualification.
    wait_for(1, 1'b0, 200, n);
    pll_locked = 1'b1;
    repeat (7) tick();
    pll_locked = 1'b0;
    repeat (2) tick();
    pll_locked = 1'b1;
    wait_for(0, 1'b1, 200, n);
    check_eq("glitch_relatency", n - 1, SS + LSC + RHC);

    // Soft reset holds sys_reset_n low for the hold window only.
    repeat (5) tick();
    soft_reset_req = 1'b1;
    tick();
    soft_reset_req = 1'b0;
    check_eq("soft_fall", sys_reset_n, 0);
    wait_for(0, 1'b1, 20, n);
    low = n;
    check_eq("soft_low_cycles", low, RHC);

    // Soft reset coincident with lock loss: lock loss wins.
    repeat (3) tick();
    r0 = relock_count;
    pll_locked = 1'b0;
    repeat (2) tick();
    soft_reset_req = 1'b1;
    tick();
    soft_reset_req = 1'b0;
    check_eq("coinc_sys", sys_reset_n, 0);
    check_eq("coinc_relock", relock_count, r0 + 1);
    repeat (4) tick();

    // Repeated lock losses saturate the counter.
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b1;
      wait_for(0, 1'b1, 100, n);
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 3) == 0) begin
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        wait_for(0, 1'b1, 20, n);
      end
      pll_locked = 1'b0;
      wait_for(0, 1'b0, 20, n);
    end
    check_eq("relock_saturated", relock_count, 255);

    // Random lock traffic with one asynchronous reset in the middle.
    hold_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold_left == 0) begin
        pll_locked = ~pll_locked;
        hold_left  = pll_locked ? $urandom_range(1, 60) : $urandom_range(1, 90);
      end
      hold_left--;
      soft_reset_req = ($urandom_range(0, 15) == 0);
      if (c == 1500) begin
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_pll_rst", pll_rst, 1);
        check_eq("async_sys_reset_n", sys_reset_n, 0);
        check_eq("async_ready", ready, 0);
        check_eq("async_relock", relock_count, 0);
        model_reset();
        repeat (2) tick();
        reset_n = 1'b1;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
